// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for common-anode 7-segment digits.
// Each digit slot is a blanking guard followed by a drive window. New display
// values arrive via ready/valid and are committed only at frame boundaries.
// Optional feature macro: SEG_SCAN_LZ_BLANK_EN (leading-zero suppression).
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SLOT_CYCLES  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  input  logic [NUM_DIGITS-1:0]   digit_mask,
  output logic [3:0]              code_out,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int unsigned DATA_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W  = $clog2(SLOT_CYCLES);
  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   active_q, active_d;
  logic [DATA_W-1:0]   pending_q, pending_d;
  logic                ready_d;
  logic [3:0]          code_d;
  logic [NUM_DIGITS-1:0] an_d;
  logic                frame_done_d;
  logic                boundary;
  logic                accept;
  logic                commit;
  logic [NUM_DIGITS-1:0] visible;

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_q, lz_d;

  // Digits at or below the highest nonzero nibble stay lit; digit 0 always lit.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [DATA_W-1:0] v);
    logic seen;
    seen    = 1'b0;
    lz_mask = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      seen       = seen | (v[4*i +: 4] != 4'h0);
      lz_mask[i] = seen;
    end
    lz_mask[0] = 1'b1;
  endfunction
`endif

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BLANK;
      cnt_q      <= '0;
      idx_q      <= '0;
      active_q   <= '0;
      pending_q  <= '0;
      load_ready <= 1'b1;
      code_out   <= 4'h0;
      an_n       <= '1;
      frame_done <= 1'b0;
`ifdef SEG_SCAN_LZ_BLANK_EN
      lz_q       <= NUM_DIGITS'(1);
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      load_ready <= ready_d;
      code_out   <= code_d;
      an_n       <= an_d;
      frame_done <= frame_done_d;
`ifdef SEG_SCAN_LZ_BLANK_EN
      lz_q       <= lz_d;
`endif
    end
  end

  // Next-state, handshake and next-output logic; outputs track the next state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    boundary     = 1'b0;
    accept       = 1'b0;
    commit       = 1'b0;
    pending_d    = pending_q;
    ready_d      = load_ready;
    active_d     = active_q;
    code_d       = 4'h0;
    an_d         = '1;
    frame_done_d = 1'b0;
    visible      = digit_mask;
`ifdef SEG_SCAN_LZ_BLANK_EN
    lz_d         = lz_q;
`endif

    // Slot sequencing: blank guard, then drive, then advance the digit.
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == CNT_W'(SLOT_CYCLES - 1)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            idx_d    = '0;
            boundary = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    // A pending value can only commit when the buffer was already full, so a
    // load accepted on the boundary cycle waits for the following boundary.
    accept = load_valid & load_ready;
    commit = boundary & ~load_ready;

    if (accept) begin
      pending_d = load_data;
      ready_d   = 1'b0;
    end
    if (commit) begin
      active_d = pending_q;
      ready_d  = 1'b1;
`ifdef SEG_SCAN_LZ_BLANK_EN
      lz_d     = lz_mask(pending_q);
`endif
    end

`ifdef SEG_SCAN_LZ_BLANK_EN
    visible = digit_mask & lz_d;
`endif

    code_d       = active_d[{idx_d, 2'b00} +: 4];
    frame_done_d = boundary;
    if (state_d == ST_DRIVE) begin
      an_d[idx_d] = ~visible[idx_d];
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl. A time-based reference
// model predicts every cycle's outputs into a queue; a monitor pops and checks.
// Honours SEG_SCAN_LZ_BLANK_EN when defined for both bench and design.
module tb_seg_scan_ctrl;

  localparam int unsigned ND = 4;
  localparam int unsigned SC = 8;
  localparam int unsigned BC = 2;
  localparam int unsigned FR = ND * SC;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic [15:0]   load_data;
  logic          load_ready;
  logic [3:0]    digit_mask;
  logic [3:0]    code_out;
  logic [3:0]    an_n;
  logic          frame_done;

  typedef struct {
    logic [3:0] code;
    logic [3:0] an;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t q[$];

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model state: cycle position since reset, committed and pending values.
  int unsigned m_t      = 0;
  logic [15:0] m_active = 16'h0;
  logic [15:0] m_pend   = 16'h0;
  logic        m_pv     = 1'b0;

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .SLOT_CYCLES (SC),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .digit_mask(digit_mask),
    .code_out  (code_out),
    .an_n      (an_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", nm, $time, act, want);
    end
  endtask

  // Whether a digit is allowed to light given the committed value.
  function automatic bit lz_ok(input int unsigned dig, input logic [15:0] val);
`ifdef SEG_SCAN_LZ_BLANK_EN
    return (dig == 0) || ((val >> (4 * dig)) != 16'h0);
`else
    return 1'b1;
`endif
  endfunction

  // Reference model: advances one cycle per edge and queues the expected outputs.
  initial begin
    forever begin
      exp_t        e;
      bit          bnd, commit, accept;
      int unsigned phase, dig;
      @(posedge clk);
      if (rst) begin
        m_t      = 0;
        m_active = 16'h0;
        m_pv     = 1'b0;
        e = '{code: 4'h0, an: 4'hF, fd: 1'b0, rdy: 1'b1};
      end else begin
        bnd    = ((m_t % FR) == FR - 1);
        commit = bnd && m_pv;
        accept = load_valid && !m_pv;
        if (commit) begin
          m_active = m_pend;
          m_pv     = 1'b0;
        end
        if (accept) begin
          m_pend = load_data;
          m_pv   = 1'b1;
        end
        m_t    = m_t + 1;
        phase  = m_t % SC;
        dig    = (m_t / SC) % ND;
        e.code = m_active[dig*4 +: 4];
        e.an   = 4'hF;
        if (phase >= BC && digit_mask[dig] && lz_ok(dig, m_active)) e.an[dig] = 1'b0;
        e.fd   = bnd;
        e.rdy  = !m_pv;
      end
      q.push_back(e);
    end
  end

  // Monitor: compares DUT outputs against the oldest queued prediction.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("code_out",   32'(code_out),   32'(e.code));
        chk("an_n",       32'(an_n),       32'(e.an));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
        chk("load_ready", 32'(load_ready), 32'(e.rdy));
      end
    end
  end

  // Wait (bounded) until the current cycle sits at a given frame position.
  task automatic wait_phase(input int unsigned ph, input bit need_empty);
    int unsigned n = 0;
    while (!(((m_t % FR) == ph) && (!need_empty || !m_pv))) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        total++;
        bad++;
        $display("FAIL wait_phase: got=timeout want=phase %0d", ph);
        return;
      end
    end
  endtask

  task automatic load_at(input int unsigned ph, input logic [15:0] val);
    wait_phase(ph, 1'b1);
    load_valid = 1'b1;
    load_data  = val;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 16'h0;
    digit_mask = 4'hF;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle scanning with all digits enabled.
    repeat (70) @(negedge clk);

    // Mid-frame load, then a second offer while busy that must be dropped.
    wait_phase(10, 1'b1);
    load_valid = 1'b1;
    load_data  = 16'h1234;
    @(negedge clk);
    load_data  = 16'hBEEF;
    repeat (3) @(negedge clk);
    load_valid = 1'b0;
    repeat (2 * FR) @(negedge clk);

    // Load accepted on the boundary cycle itself.
    load_at(FR - 1, 16'h5A5A);
    repeat (2 * FR + 8) @(negedge clk);

    // Partial digit mask.
    digit_mask = 4'b0101;
    repeat (FR + 8) @(negedge clk);
    digit_mask = 4'hF;

    // Reset during digit 2 drive with a value still pending.
    load_at(5, 16'h00A0);
    wait_phase(2 * SC + 4, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (FR + 8) @(negedge clk);

    // Values that exercise leading-zero suppression when it is built.
    load_at(5, 16'h00A0);
    repeat (2 * FR) @(negedge clk);
    load_at(5, 16'h0000);
    repeat (2 * FR) @(negedge clk);
    load_at(5, 16'h0F00);
    repeat (2 * FR) @(negedge clk);

    // Randomized traffic.
    for (int i = 0; i < 1200; i++) begin
      load_valid = ($urandom_range(0, 7) == 0);
      load_data  = 16'($urandom);
      if ($urandom_range(0, 49) == 0) digit_mask = 4'($urandom);
      rst = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    load_valid = 1'b0;
    rst        = 1'b0;
    repeat (4) @(negedge clk);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of common-anode 7-segment digits.
- All digits share one hex-to-segment decoder; this block sequences which 4-bit code feeds it and which anode is enabled.
- Inserts a blanking guard between digits to prevent ghosting.
- Accepts new display values through a ready/valid handshake; updates commit only at frame boundaries, so a frame never shows torn data.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (2..16).
- SLOT_CYCLES, 100000, clk cycles per digit slot, blank plus drive (> BLANK_CYCLES).
- BLANK_CYCLES, 1000, cycles at start of each slot with all anodes off (>= 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  new display value offered.
- load_data  in  4*NUM_DIGITS  nibble i = code for digit i; digit 0 is rightmost/least significant.
- load_ready  out  1  pending buffer empty; load accepted when load_valid && load_ready.
- digit_mask  in  NUM_DIGITS  1 = digit enabled; sampled live each cycle.
- code_out  out  4  code for the current digit, to the segment decoder.
- an_n  out  NUM_DIGITS  active-low anode enables; at most one low at a time.
- frame_done  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset values: an_n all 1s, code_out 0, frame_done 0, load_ready 1, active register 0, pending empty, digit index 0, slot counter 0, state BLANK.
- All outputs are registered.
- State machine:
  - BLANK: counter runs 0..BLANK_CYCLES-1.
  - DRIVE: counter runs BLANK_CYCLES..SLOT_CYCLES-1.
  - BLANK -> DRIVE when counter == BLANK_CYCLES-1.
  - DRIVE -> BLANK when counter == SLOT_CYCLES-1; counter returns to 0 and digit index advances.
- code_out holds active nibble[idx] for the whole slot, both BLANK and DRIVE.
- In BLANK, an_n is all 1s.
- In DRIVE, an_n[idx] = ~digit_mask[idx]; all other bits are 1.
- Digit index wraps NUM_DIGITS-1 -> 0.
- Frame boundary = the DRIVE -> BLANK transition out of digit NUM_DIGITS-1. On the following cycle:
  - frame_done = 1 for exactly one cycle.
  - If pending is valid: active <= pending, pending cleared, load_ready rises that same cycle.
- Handshake:
  - On an accepted load, the data is stored in pending and load_ready drops the next cycle.
  - load_data is ignored while load_ready = 0; no overwrite and no error.
  - A load accepted in the same cycle as a frame boundary commits at the next boundary, not the current one.
- Frame length = NUM_DIGITS * SLOT_CYCLES cycles. Counter width = clog2(SLOT_CYCLES). Index width = clog2(NUM_DIGITS).
- digit_mask changes take effect on the next cycle with no boundary alignment.
- Reset asserted mid-slot or mid-frame:
  - Next cycle returns all reset values.
  - Pending data is discarded.
  - No frame_done pulse is generated.

Optional Feature:
- Macro: SEG_SCAN_LZ_BLANK_EN.
- Defined: leading-zero suppression.
  - Computed from the active register at commit time.
  - Every digit above the highest nonzero nibble is forced off (an_n bit stays 1 in DRIVE).
  - Digit 0 is always shown, even when the value is 0.
  - digit_mask still applies, ANDed with the suppression result.
- Undefined: no suppression logic is built; all digits follow digit_mask only.

Test Plan (NUM_DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2, frame = 32 cycles):
- Reset release, mask=4'hF, no load -> code_out=0; an_n=4'b1111 for cycles 0-1 and 4'b1110 for cycles 2-7; then 4'b1101 from cycle 10; frame_done pulses once every 32 cycles.
- Load 16'h1234 mid-frame -> load_ready=0 next cycle; digits keep showing 0 until the boundary; next frame digit0..3 code_out = 4,3,2,1; load_ready=1 in the frame_done cycle.
- Second load (16'hBEEF) while load_ready=0 -> ignored; only 16'h1234 ever appears.
- Load accepted in the frame_done-triggering boundary cycle -> old value shown for one more full frame, new value the frame after.
- mask=4'b0101 -> an_n never goes low for digits 1 and 3; blanking on digits 0 and 2 is unchanged; code_out still cycles through all four nibbles.
- rst pulsed during digit 2 DRIVE with pending 16'h00A0 -> next cycle an_n=4'hF and load_ready=1; following frame shows 0 (pending discarded).
- With SEG_SCAN_LZ_BLANK_EN defined, after committing 16'h00A0 -> digits 3 and 2 dark, digits 1 and 0 lit; after committing 16'h0000 -> only digit 0 lit.
